// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins ties; every access is bounded by a watchdog that completes it with zero data.
module imem_dmem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ice,
    input  logic [31:0] iaddr,
    output logic [31:0] inst,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  dwe,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        mem_ce,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      inst_q;
    logic [31:0]      drdata_q;
    logic             busy;
    logic             timeout;
    logic             done;
    logic             i_done;
    logic             d_done;

    assign busy    = (state != IDLE);
    assign timeout = busy && (cnt == CNT_LAST) && !mem_ready;
    assign done    = mem_ready || timeout;
    assign i_done  = (state == I_BUSY) && done;
    assign d_done  = (state == D_BUSY) && done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dce) begin
                    next_state = D_BUSY;
                end else if (ice) begin
                    next_state = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Memory-side request registers stay frozen for the whole busy period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ce    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_we    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_ce <= (next_state != IDLE);
            if (state == IDLE) begin
                if (dce) begin
                    mem_addr  <= daddr;
                    mem_we    <= dwe;
                    mem_wdata <= dwdata;
                end else if (ice) begin
                    mem_addr <= iaddr;
                    mem_we   <= 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (!busy) begin
                cnt <= '0;
            end else if (!mem_ready) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    // A timed-out read returns zero rather than whatever is on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q   <= 32'd0;
            drdata_q <= 32'd0;
        end else begin
            if (i_done) begin
                inst_q <= mem_ready ? mem_rdata : 32'd0;
            end
            if (d_done && (mem_we == 4'd0)) begin
                drdata_q <= mem_ready ? mem_rdata : 32'd0;
            end
        end
    end

    assign inst   = ((state == I_BUSY) && mem_ready) ? mem_rdata : inst_q;
    assign drdata = ((state == D_BUSY) && mem_ready) ? mem_rdata : drdata_q;

    assign stallreq_if  = ice && !i_done;
    assign stallreq_mem = dce && !d_done;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: fetch, priority, wait states, timeout, reset, flush.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  dwe;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        err;

    int checks;
    int failures;

    imem_dmem_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ice          (ice),
        .iaddr        (iaddr),
        .inst         (inst),
        .dce          (dce),
        .daddr        (daddr),
        .dwe          (dwe),
        .dwdata       (dwdata),
        .drdata       (drdata),
        .mem_ce       (mem_ce),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ice = 0; iaddr = 0; dce = 0; daddr = 0; dwe = 0; dwdata = 0;
        mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL reset_mem_ce got=%0b exp=0", mem_ce); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if (inst !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (drdata !== 32'd0) begin failures++; $display("FAIL reset_drdata got=%h exp=0", drdata); end
        checks++; if ({stallreq_if, stallreq_mem} !== 2'b00) begin failures++; $display("FAIL reset_stall got=%b exp=00", {stallreq_if, stallreq_mem}); end
    endtask

    task automatic test_fetch_zero_wait();
        tick();
        ice = 1; iaddr = 32'h100;
        #1;
        checks++; if (stallreq_if !== 1'b1) begin failures++; $display("FAIL f0_stall_idle got=%0b exp=1", stallreq_if); end
        tick();
        checks++; if (mem_ce !== 1'b1) begin failures++; $display("FAIL f0_mem_ce got=%0b exp=1", mem_ce); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL f0_mem_addr got=%h exp=100", mem_addr); end
        checks++; if (mem_we !== 4'h0) begin failures++; $display("FAIL f0_mem_we got=%h exp=0", mem_we); end
        mem_ready = 1; mem_rdata = 32'h24020005;
        #1;
        checks++; if (stallreq_if !== 1'b0) begin failures++; $display("FAIL f0_stall_ready got=%0b exp=0", stallreq_if); end
        checks++; if (inst !== 32'h24020005) begin failures++; $display("FAIL f0_inst_bypass got=%h exp=24020005", inst); end
        tick();
        ice = 0; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (inst !== 32'h24020005) begin failures++; $display("FAIL f0_inst_held got=%h exp=24020005", inst); end
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL f0_idle_ce got=%0b exp=0", mem_ce); end
    endtask

    task automatic test_priority();
        ice = 1; iaddr = 32'h104; dce = 1; daddr = 32'h2000; dwe = 4'hF; dwdata = 32'hDEADBEEF;
        #1;
        checks++; if ({stallreq_if, stallreq_mem} !== 2'b11) begin failures++; $display("FAIL pr_stall_idle got=%b exp=11", {stallreq_if, stallreq_mem}); end
        tick();
        checks++; if (mem_addr !== 32'h2000) begin failures++; $display("FAIL pr_d_addr got=%h exp=2000", mem_addr); end
        checks++; if (mem_we !== 4'hF) begin failures++; $display("FAIL pr_d_we got=%h exp=f", mem_we); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL pr_d_wdata got=%h exp=deadbeef", mem_wdata); end
        mem_ready = 1; mem_rdata = 32'hAAAA5555;
        #1;
        checks++; if ({stallreq_if, stallreq_mem} !== 2'b10) begin failures++; $display("FAIL pr_stall_dready got=%b exp=10", {stallreq_if, stallreq_mem}); end
        tick();
        dce = 0; dwe = 0; mem_ready = 0;
        #1;
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL pr_gap_ce got=%0b exp=0", mem_ce); end
        checks++; if (stallreq_if !== 1'b1) begin failures++; $display("FAIL pr_gap_stall_if got=%0b exp=1", stallreq_if); end
        checks++; if (drdata !== 32'd0) begin failures++; $display("FAIL pr_store_drdata got=%h exp=0", drdata); end
        tick();
        checks++; if (mem_addr !== 32'h104) begin failures++; $display("FAIL pr_i_addr got=%h exp=104", mem_addr); end
        checks++; if (mem_we !== 4'h0) begin failures++; $display("FAIL pr_i_we got=%h exp=0", mem_we); end
        mem_ready = 1; mem_rdata = 32'h11112222;
        #1;
        checks++; if (inst !== 32'h11112222) begin failures++; $display("FAIL pr_inst got=%h exp=11112222", inst); end
        tick();
        ice = 0; mem_ready = 0;
        #1;
    endtask

    task automatic test_wait_states();
        dce = 1; daddr = 32'h3000; dwe = 0; dwdata = 32'h0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_addr !== 32'h3000) begin failures++; $display("FAIL ws_addr_c%0d got=%h exp=3000", i, mem_addr); end
            checks++; if (stallreq_mem !== 1'b1) begin failures++; $display("FAIL ws_stall_c%0d got=%0b exp=1", i, stallreq_mem); end
            tick();
        end
        mem_ready = 1; mem_rdata = 32'h12345678;
        #1;
        checks++; if (drdata !== 32'h12345678) begin failures++; $display("FAIL ws_drdata_bypass got=%h exp=12345678", drdata); end
        checks++; if (stallreq_mem !== 1'b0) begin failures++; $display("FAIL ws_stall_ready got=%0b exp=0", stallreq_mem); end
        tick();
        dce = 0; mem_ready = 0; mem_rdata = 32'h0;
        #1;
        checks++; if (drdata !== 32'h12345678) begin failures++; $display("FAIL ws_drdata_held got=%h exp=12345678", drdata); end
    endtask

    task automatic test_timeout();
        ice = 1; iaddr = 32'h200;
        tick();
        for (int i = 1; i < 16; i++) begin
            #1;
            if (stallreq_if !== 1'b1 || err !== 1'b0) begin
                checks++; failures++;
                $display("FAIL to_busy_c%0d stall=%0b err=%0b exp stall=1 err=0", i, stallreq_if, err);
            end
            tick();
        end
        #1;
        checks++; if (stallreq_if !== 1'b0) begin failures++; $display("FAIL to_stall_drop got=%0b exp=0", stallreq_if); end
        tick();
        ice = 0;
        #1;
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL to_idle_ce got=%0b exp=0", mem_ce); end
        checks++; if (inst !== 32'd0) begin failures++; $display("FAIL to_inst_zero got=%h exp=0", inst); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_set got=%0b exp=1", err); end
        dce = 1; daddr = 32'h40; dwe = 0;
        tick();
        mem_ready = 1; mem_rdata = 32'hCAFE0001;
        tick();
        dce = 0; mem_ready = 0;
        #1;
        checks++; if (drdata !== 32'hCAFE0001) begin failures++; $display("FAIL to_after_load got=%h exp=cafe0001", drdata); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%0b exp=1", err); end
    endtask

    task automatic test_reset_mid_access();
        dce = 1; daddr = 32'h500; dwe = 0;
        tick();
        checks++; if (mem_ce !== 1'b1) begin failures++; $display("FAIL rm_busy_ce got=%0b exp=1", mem_ce); end
        #2;
        rst = 1;
        #1;
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL rm_async_ce got=%0b exp=0", mem_ce); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rm_async_err got=%0b exp=0", err); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL rm_async_addr got=%h exp=0", mem_addr); end
        checks++; if (drdata !== 32'd0) begin failures++; $display("FAIL rm_async_drdata got=%h exp=0", drdata); end
        tick();
        rst = 0; dce = 0;
        mem_ready = 1; mem_rdata = 32'h99999999;
        #1;
        checks++; if (drdata !== 32'd0) begin failures++; $display("FAIL rm_late_bypass got=%h exp=0", drdata); end
        tick();
        mem_ready = 0;
        #1;
        checks++; if (drdata !== 32'd0) begin failures++; $display("FAIL rm_late_drdata got=%h exp=0", drdata); end
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL rm_late_ce got=%0b exp=0", mem_ce); end
    endtask

    task automatic test_flush();
        ice = 1; iaddr = 32'h600;
        tick();
        ice = 0;
        #1;
        checks++; if (stallreq_if !== 1'b0) begin failures++; $display("FAIL fl_stall_drop got=%0b exp=0", stallreq_if); end
        checks++; if (mem_ce !== 1'b1) begin failures++; $display("FAIL fl_still_busy got=%0b exp=1", mem_ce); end
        tick();
        checks++; if (mem_ce !== 1'b1) begin failures++; $display("FAIL fl_busy_c2 got=%0b exp=1", mem_ce); end
        mem_ready = 1; mem_rdata = 32'h77777777;
        tick();
        mem_ready = 0; mem_rdata = 32'h0;
        ice = 1; iaddr = 32'h700;
        #1;
        checks++; if (inst !== 32'h77777777) begin failures++; $display("FAIL fl_inst_latched got=%h exp=77777777", inst); end
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL fl_gap_ce got=%0b exp=0", mem_ce); end
        checks++; if (stallreq_if !== 1'b1) begin failures++; $display("FAIL fl_gap_stall got=%0b exp=1", stallreq_if); end
        tick();
        checks++; if (mem_addr !== 32'h700) begin failures++; $display("FAIL fl_next_addr got=%h exp=700", mem_addr); end
        mem_ready = 1; mem_rdata = 32'h0BADF00D;
        tick();
        ice = 0; mem_ready = 0;
        #1;
        checks++; if (inst !== 32'h0BADF00D) begin failures++; $display("FAIL fl_next_inst got=%h exp=0badf00d", inst); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fetch_zero_wait();
        test_priority();
        test_wait_states();
        test_timeout();
        test_reset_mid_access();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
